sseg_scan_capture: RTL

- Receive-side counterpart of the 4-digit multiplexed seven-segment driver.
- Watches the multiplexed active-low cathode and anode lines and rebuilds the four displayed hex digits and decimal points.
- Reports per-digit glyph validity and pulses once per completed refresh frame.
- Used as a loopback monitor on the board top and as a self-checking probe in display benches.

---
 rtl/sseg_pkg.sv | 16 +
 rtl/sseg_glyph_decode.sv | 28 ++
 rtl/sseg_scan_capture.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and types for the seven-segment capture path.
//   NUM_DIGITS  - number of multiplexed digits
//   cathode_t   - {dp,g,f,e,d,c,b,a} cathode bundle
//   GLYPH_TABLE - active-high gfedcba pattern for hex values 0..F (index = value)
package sseg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [7:0] cathode_t;

  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sseg_glyph_decode.sv
// sseg_glyph_decode: combinational glyph-to-hex lookup.
//   pattern - active-high gfedcba segment pattern
//   value   - hex value of the matching glyph (0 when no match)
//   match   - pattern is one of the sixteen hex glyphs
//   all_off - every segment is dark
module sseg_glyph_decode
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       match,
  output logic       all_off
);

  always_comb begin
    value = '0;
    match = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        value = 4'(i);
        match = 1'b1;
      end
    end
  end

  assign all_off = (pattern == '0);

endmodule

// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: rebuilds the digits shown by a multiplexed 4-digit
// seven-segment driver from its active-low anode/cathode lines.
//   clk, rst          - clock, asynchronous active-high reset
//   segment_cathodes  - active-low {dp,g,f,e,d,c,b,a}
//   digit_anodes      - active-low digit select, bit N = digit N
//   digit0..digit3    - last valid decoded hex value per digit
//   decimals          - captured decimal point per digit (active-high)
//   digit_valid       - last capture of digit N matched a hex glyph
//   frame_done        - one-cycle pulse when all digits have been captured
//   err_anode         - sticky: several anodes low at a capture point
//   blank             - all-segments-off flag per digit (SSEG_CAPTURE_BLANK_EN)
module sseg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            segment_cathodes,
  input  logic [NUM_DIGITS-1:0] digit_anodes,
  output logic [3:0]            digit0,
  output logic [3:0]            digit1,
  output logic [3:0]            digit2,
  output logic [3:0]            digit3,
  output logic [NUM_DIGITS-1:0] decimals,
  output logic [NUM_DIGITS-1:0] digit_valid,
  output logic                  frame_done,
  output logic                  err_anode
`ifdef SSEG_CAPTURE_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0] blank
`endif
);

  import sseg_pkg::*;

  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [7:0]  CAPTURE_AT = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  CNT_SAT    = 8'(SETTLE_CYCLES);

  cathode_t              cath_r1, cath_r2;
  logic [NUM_DIGITS-1:0] an_r1, an_r2;
  logic [7:0]            cnt;
  logic [NUM_DIGITS-1:0] seen;
  logic [3:0]            digit_q [NUM_DIGITS];

  logic                  inputs_stable;
  logic                  capture;
  logic [NUM_DIGITS-1:0] an_act;
  logic                  an_onehot;
  logic                  an_multi;
  logic [IDX_W-1:0]      sel_idx;
  logic [NUM_DIGITS-1:0] seen_next;

  logic [3:0]            glyph_value;
  logic                  glyph_match;
  logic                  glyph_all_off;

  sseg_glyph_decode u_decode (
    .pattern (~cath_r2[6:0]),
    .value   (glyph_value),
    .match   (glyph_match),
    .all_off (glyph_all_off)
  );

`ifndef SSEG_CAPTURE_BLANK_EN
  logic unused_all_off;
  assign unused_all_off = glyph_all_off;
`endif

  assign inputs_stable = (cath_r1 == cath_r2) && (an_r1 == an_r2);
  // cnt is still at CAPTURE_AT while saturated-1 only once per dwell, so a
  // dwell longer than the settle time cannot produce a second capture.
  assign capture       = inputs_stable && (cnt == CAPTURE_AT);

  assign an_act    = ~an_r2;
  assign an_onehot = $onehot(an_act);
  assign an_multi  = (an_act != '0) && !an_onehot;
  assign seen_next = seen | an_act;

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (an_act[i]) sel_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cath_r1 <= '1;
      cath_r2 <= '1;
      an_r1   <= '1;
      an_r2   <= '1;
      cnt     <= '0;
    end else begin
      cath_r1 <= segment_cathodes;
      cath_r2 <= cath_r1;
      an_r1   <= digit_anodes;
      an_r2   <= an_r1;
      if (!inputs_stable) begin
        cnt <= '0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      decimals    <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err_anode   <= 1'b0;
      seen        <= '0;
`ifdef SSEG_CAPTURE_BLANK_EN
      blank       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        if (an_onehot) begin
          decimals[sel_idx] <= ~cath_r2[7];
`ifdef SSEG_CAPTURE_BLANK_EN
          if (glyph_all_off) begin
            blank[sel_idx]       <= 1'b1;
            digit_valid[sel_idx] <= 1'b0;
          end else begin
            blank[sel_idx]       <= 1'b0;
            digit_valid[sel_idx] <= glyph_match;
            if (glyph_match) digit_q[sel_idx] <= glyph_value;
          end
`else
          digit_valid[sel_idx] <= glyph_match;
          if (glyph_match) digit_q[sel_idx] <= glyph_value;
`endif
          if (seen_next == '1) begin
            frame_done <= 1'b1;
            seen       <= '0;
          end else begin
            seen <= seen_next;
          end
        end else if (an_multi) begin
          err_anode <= 1'b1;
        end
      end
    end
  end

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];

endmodule
